intersection_model: RTL and testbench
=====================================

# intersection_model

Behavioural-synthesizable model of the 3-street intersection seen from the road side. It takes the three light colours driven by the traffic light controller and per-lane car-arrival pulses, and keeps a car queue per lane. It drives the three traffic sensors back to the controller and checks the light sequence for safety violations. It closes the loop around the controller in bench and FPGA demo builds.

## Interface
Parameters:
- QDEPTH, 15: max cars queued per lane; queue counters are $clog2(QDEPTH+1) bits wide.
- WAITW, 8: width of wait-time counters (saturating).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clk at the integrating level.
- arr_ews, arr_ewl, arr_ns  input  1 each  one car arrives at the EW straight, EW left or NS lane on this cycle.
- ew_str_light, ew_left_light, ns_light  input  colors  light colours from the controller (red/yellow/green from light_package).
- ew_str_sensor, ew_left_sensor, ns_sensor  output  1 each  lane queue nonzero.
- q_ews, q_ewl, q_ns  output  $clog2(QDEPTH+1)  current queue lengths.
- drop_cnt  output  8  total arrivals lost to full queues, all lanes; saturates at 255.
- max_wait  output  WAITW  longest continuous wait seen by any nonempty lane while its light was not green.
- err_conflict  output  1  sticky: two or more lights non-red in the same cycle.
- err_yellow  output  1  sticky: a yellow run lasted other than exactly 2 cycles, or green was not followed by yellow.
- err_allred  output  1  sticky: a light turned green on the cycle right after any light was yellow.

## Operation
- Per lane, evaluated each cycle:
  - dep = (light == green) && (q != 0).
  - arr_eff = arr && !(q == QDEPTH && !dep).
  - q_next = q + arr_eff − dep.
- Simultaneous arrival and departure leaves q unchanged. This is also true at q == QDEPTH, where the arrival is accepted.
- An arrival rejected because the queue is full increments drop_cnt by 1 per lane per cycle. Up to 3 drops can be added in one cycle. drop_cnt saturates at 255 and does not wrap.
- sensor = (q != 0), taken from the registered q.
- Wait counter per lane:
  - Cleared when light == green or q == 0.
  - Otherwise increments by 1 and saturates at 2^WAITW−1.
  - max_wait follows the running maximum of the three wait counters.
- Checker state, registered: the previous colour of each light and a 2-bit yellow-run counter per light.
  - err_yellow is set on any of these:
    - green→red directly.
    - yellow→green.
    - yellow→red with a yellow run ≠ 2.
    - a yellow run reaching 3.
  - err_conflict is set when any cycle samples more than one non-red light.
  - err_allred is set when a light is green this cycle, was not green last cycle, and any light was yellow last cycle.
- Error flags are sticky and cleared only by reset. Checking is suspended on the first cycle after reset release because no previous colour is valid yet.
- Reset values: all queues 0, all sensors 0, drop_cnt 0, max_wait 0, all err flags 0, previous colours red, yellow runs 0.
- Assertion of reset mid-operation clears everything immediately, asynchronously, including queued cars.

## Timing
- Every output is a register output; there are no combinational input-to-output paths.
- An arrival pulse sampled at edge n gives q+1 and sensor = 1 after edge n.
- A departure reduces q at the same edge at which the light is sampled green. The controller therefore sees sensor = 0 one cycle after the last car leaves.
- Error flags rise one cycle after the offending colour is sampled.
- max_wait lags the wait counters by one cycle.

## Structure
- Use the existing colors typedef (red/yellow/green) from light_package.
- Add to light_package:
  - a lane_t enum {EWS, EWL, NS};
  - a YELLOW_CYCLES = 2 constant shared with the controller.
- Sub-module lane_queue, instantiated 3×. It contains the queue counter, sensor, drop pulse and wait counter.
- The top level holds:
  - the drop_cnt accumulator;
  - the max_wait logic;
  - the sequence checker.

## Test plan
- Reset and arrivals: hold reset = 0 for 3 cycles, then release; pulse arr_ews for 3 cycles with all lights red. Required: q_ews = 3, ew_str_sensor = 1, wait counter 1..3, max_wait = 3.
- Drain: with q_ews = 3, drive ew_str_light green for 4 cycles with no arrivals. Required: q_ews steps 2, 1, 0, then stays at 0; ew_str_sensor drops after the third departure.
- Full queue with QDEPTH = 15:
  - Fill q_ns to 15, then hold arr_ns with ns_light red for 2 cycles. Required: q_ns = 15, drop_cnt = 2.
  - Then set green with arr_ns still high. Required: q_ns stays 15 and there are no further drops.
- Conflict: drive ew_str_light green and ns_light yellow in one cycle. Required: err_conflict = 1 the next cycle, and it stays 1 until reset.
- Yellow and all-red: drive ew_str_light G, Y, R and, on the same cycle it goes R, drive ns_light G. Required: err_yellow = 1 (1-cycle yellow) and err_allred = 1. A legal sequence G, Y, Y, R, R then NS G leaves both flags 0.
- Closed loop: connect to traffic_light_controller with random arrivals for 2000 cycles. Required: all err flags 0, max_wait < 40, and every queue returns to 0 after arrivals stop.

Source files
------------

// File: rtl/light_package.sv
// Shared light colours, lane names and timing constants for the
// traffic light controller and its road-side intersection model.
package light_package;

    typedef enum logic [1:0] {
        red    = 2'd0,
        yellow = 2'd1,
        green  = 2'd2
    } colors;

    typedef enum logic [1:0] {
        EWS = 2'd0,
        EWL = 2'd1,
        NS  = 2'd2
    } lane_t;

    localparam int unsigned YELLOW_CYCLES = 2;

endpackage

// File: rtl/lane_queue.sv
// One road lane: car queue with full-queue drop pulse, presence sensor
// and a saturating wait counter for cars held at a non-green light.
module lane_queue
    import light_package::*;
#(
    parameter  int QDEPTH = 15,
    parameter  int WAITW  = 8,
    localparam int QW     = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arr,
    input  colors            light,
    output logic [QW-1:0]    q,
    output logic             sensor,
    output logic             drop,
    output logic [WAITW-1:0] wait_cnt
);

    localparam logic [QW-1:0]    QFULL = QW'(QDEPTH);
    localparam logic [QW-1:0]    QONE  = QW'(1);
    localparam logic [WAITW-1:0] WMAX  = '1;
    localparam logic [WAITW-1:0] WONE  = WAITW'(1);

    logic          dep;
    logic          arr_eff;
    logic [QW-1:0] q_next;

    assign dep     = (light == green) && (q != '0);
    assign arr_eff = arr && !((q == QFULL) && !dep);
    assign drop    = arr && !arr_eff;

    always_comb begin
        q_next = q;
        if (arr_eff && !dep) begin
            q_next = q + QONE;
        end else if (!arr_eff && dep) begin
            q_next = q - QONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q        <= '0;
            sensor   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            q      <= q_next;
            sensor <= (q_next != '0);
            if ((light == green) || (q == '0)) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WMAX) begin
                wait_cnt <= wait_cnt + WONE;
            end
        end
    end

endmodule

// File: rtl/intersection_model.sv
// Road side of the 3-street intersection: lane queues, drop and wait
// statistics, and a sticky safety checker on the controller's lights.
module intersection_model
    import light_package::*;
#(
    parameter  int QDEPTH = 15,
    parameter  int WAITW  = 8,
    localparam int QW     = $clog2(QDEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arr_ews,
    input  logic             arr_ewl,
    input  logic             arr_ns,
    input  colors            ew_str_light,
    input  colors            ew_left_light,
    input  colors            ns_light,
    output logic             ew_str_sensor,
    output logic             ew_left_sensor,
    output logic             ns_sensor,
    output logic [QW-1:0]    q_ews,
    output logic [QW-1:0]    q_ewl,
    output logic [QW-1:0]    q_ns,
    output logic [7:0]       drop_cnt,
    output logic [WAITW-1:0] max_wait,
    output logic             err_conflict,
    output logic             err_yellow,
    output logic             err_allred
);

    localparam logic [1:0] YC = 2'(YELLOW_CYCLES);

    colors            light  [3];
    logic [2:0]       arr;
    logic [2:0]       drop;
    logic [2:0]       sens;
    logic [QW-1:0]    q      [3];
    logic [WAITW-1:0] wcnt   [3];

    assign light[EWS] = ew_str_light;
    assign light[EWL] = ew_left_light;
    assign light[NS]  = ns_light;
    assign arr        = {arr_ns, arr_ewl, arr_ews};

    assign ew_str_sensor  = sens[EWS];
    assign ew_left_sensor = sens[EWL];
    assign ns_sensor      = sens[NS];
    assign q_ews          = q[EWS];
    assign q_ewl          = q[EWL];
    assign q_ns           = q[NS];

    for (genvar i = 0; i < 3; i++) begin : g_lane
        lane_queue #(
            .QDEPTH(QDEPTH),
            .WAITW (WAITW)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .arr     (arr[i]),
            .light   (light[i]),
            .q       (q[i]),
            .sensor  (sens[i]),
            .drop    (drop[i]),
            .wait_cnt(wcnt[i])
        );
    end

    logic [8:0]       dsum;
    logic [WAITW-1:0] wmax;

    assign dsum = {1'b0, drop_cnt} + 9'(drop[0]) + 9'(drop[1]) + 9'(drop[2]);

    always_comb begin
        wmax = max_wait;
        for (int i = 0; i < 3; i++) begin
            if (wcnt[i] > wmax) wmax = wcnt[i];
        end
    end

    // Checker: previous colour and yellow run length per light
    colors      prev      [3];
    logic [1:0] yrun      [3];
    logic [1:0] yrun_next [3];
    logic       chk_en;
    logic [2:0] nonred;
    logic       any_py;
    logic       yellow_now;
    logic       allred_now;
    logic       conflict_now;

    always_comb begin
        yellow_now = 1'b0;
        allred_now = 1'b0;
        any_py     = 1'b0;
        nonred     = '0;
        for (int i = 0; i < 3; i++) begin
            nonred[i] = (light[i] != red);
            if (prev[i] == yellow) any_py = 1'b1;
        end
        conflict_now = (nonred[0] & nonred[1]) | (nonred[0] & nonred[2]) |
                       (nonred[1] & nonred[2]);
        for (int i = 0; i < 3; i++) begin
            yrun_next[i] = 2'd0;
            if (light[i] == yellow) begin
                yrun_next[i] = (yrun[i] == 2'd3) ? 2'd3 : yrun[i] + 2'd1;
            end
            if (yrun_next[i] == 2'd3) yellow_now = 1'b1;
            unique case (1'b1)
                prev[i] == green:
                    if (light[i] == red) yellow_now = 1'b1;
                prev[i] == yellow:
                    if ((light[i] == green) ||
                        ((light[i] == red) && (yrun[i] != YC)))
                        yellow_now = 1'b1;
                default: ;
            endcase
            if ((light[i] == green) && (prev[i] != green) && any_py) begin
                allred_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt     <= '0;
            max_wait     <= '0;
            chk_en       <= 1'b0;
            err_conflict <= 1'b0;
            err_yellow   <= 1'b0;
            err_allred   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                prev[i] <= red;
                yrun[i] <= 2'd0;
            end
        end else begin
            drop_cnt     <= dsum[8] ? 8'hFF : dsum[7:0];
            max_wait     <= wmax;
            chk_en       <= 1'b1;
            err_conflict <= err_conflict | (chk_en & conflict_now);
            err_yellow   <= err_yellow   | (chk_en & yellow_now);
            err_allred   <= err_allred   | (chk_en & allred_now);
            for (int i = 0; i < 3; i++) begin
                prev[i] <= light[i];
                yrun[i] <= yrun_next[i];
            end
        end
    end

endmodule

// File: tb/tb_intersection_model.sv
// Bench for intersection_model: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_intersection_model;
    import light_package::*;

    localparam int QDEPTH = 15;
    localparam int WAITW  = 8;
    localparam int QW     = $clog2(QDEPTH + 1);
    localparam int HN     = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             arr_ews, arr_ewl, arr_ns;
    colors            ew_str_light, ew_left_light, ns_light;
    logic             ew_str_sensor, ew_left_sensor, ns_sensor;
    logic [QW-1:0]    q_ews, q_ewl, q_ns;
    logic [7:0]       drop_cnt;
    logic [WAITW-1:0] max_wait;
    logic             err_conflict, err_yellow, err_allred;

    intersection_model #(.QDEPTH(QDEPTH), .WAITW(WAITW)) dut (
        .clk           (clk),
        .reset         (reset),
        .arr_ews       (arr_ews),
        .arr_ewl       (arr_ewl),
        .arr_ns        (arr_ns),
        .ew_str_light  (ew_str_light),
        .ew_left_light (ew_left_light),
        .ns_light      (ns_light),
        .ew_str_sensor (ew_str_sensor),
        .ew_left_sensor(ew_left_sensor),
        .ns_sensor     (ns_sensor),
        .q_ews         (q_ews),
        .q_ewl         (q_ewl),
        .q_ns          (q_ns),
        .drop_cnt      (drop_cnt),
        .max_wait      (max_wait),
        .err_conflict  (err_conflict),
        .err_yellow    (err_yellow),
        .err_allred    (err_allred)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: queues, waits, statistics and colour history
    int    mq [3];
    int    mw [3];
    int    mdrop, mmax, t;
    bit    m_conf, m_yel, m_all;
    colors hist [3][HN];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s actual=%0d expected=%0d at %0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0;
            mw[i] = 0;
        end
        mdrop  = 0;
        mmax   = 0;
        m_conf = 0;
        m_yel  = 0;
        m_all  = 0;
        t      = 0;
    endtask

    function automatic int yrun_at(int i, int tt);
        int n = 0;
        while (tt >= 0 && n < 4 && hist[i][tt % HN] == yellow) begin
            n++;
            tt--;
        end
        return n;
    endfunction

    task automatic model_step(input logic [2:0] a, input colors c0,
                              input colors c1, input colors c2);
        colors c [3];
        int    nr, drops;
        bit    py, dep;
        c[0] = c0;
        c[1] = c1;
        c[2] = c2;
        for (int i = 0; i < 3; i++) hist[i][t % HN] = c[i];
        if (t >= 1) begin
            nr = 0;
            py = 0;
            for (int i = 0; i < 3; i++) begin
                if (c[i] != red) nr++;
                if (hist[i][(t - 1) % HN] == yellow) py = 1;
            end
            if (nr > 1) m_conf = 1;
            for (int i = 0; i < 3; i++) begin
                colors p;
                p = hist[i][(t - 1) % HN];
                if (p == green && c[i] == red) m_yel = 1;
                if (p == yellow && c[i] == green) m_yel = 1;
                if (p == yellow && c[i] == red && yrun_at(i, t - 1) != 2)
                    m_yel = 1;
                if (yrun_at(i, t) >= 3) m_yel = 1;
                if (c[i] == green && p != green && py) m_all = 1;
            end
        end
        for (int i = 0; i < 3; i++) if (mw[i] > mmax) mmax = mw[i];
        drops = 0;
        for (int i = 0; i < 3; i++) begin
            dep = (c[i] == green) && (mq[i] > 0);
            if (c[i] == green || mq[i] == 0) mw[i] = 0;
            else if (mw[i] < 255) mw[i]++;
            if (a[i]) begin
                if (mq[i] == QDEPTH && !dep) drops++;
                else mq[i]++;
            end
            if (dep) mq[i]--;
        end
        mdrop = (mdrop + drops > 255) ? 255 : mdrop + drops;
        t++;
    endtask

    task automatic check_all();
        chk("q_ews", int'(q_ews), mq[0]);
        chk("q_ewl", int'(q_ewl), mq[1]);
        chk("q_ns", int'(q_ns), mq[2]);
        chk("sensor_ews", int'(ew_str_sensor), int'(mq[0] != 0));
        chk("sensor_ewl", int'(ew_left_sensor), int'(mq[1] != 0));
        chk("sensor_ns", int'(ns_sensor), int'(mq[2] != 0));
        chk("drop_cnt", int'(drop_cnt), mdrop);
        chk("max_wait", int'(max_wait), mmax);
        chk("err_conflict", int'(err_conflict), int'(m_conf));
        chk("err_yellow", int'(err_yellow), int'(m_yel));
        chk("err_allred", int'(err_allred), int'(m_all));
    endtask

    // Called at a negedge: drive, advance model, clock, compare
    task automatic step(input logic [2:0] a, input colors c0,
                        input colors c1, input colors c2);
        arr_ews       = a[0];
        arr_ewl       = a[1];
        arr_ns        = a[2];
        ew_str_light  = c0;
        ew_left_light = c1;
        ns_light      = c2;
        model_step(a, c0, c1, c2);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        arr_ews       = 0;
        arr_ewl       = 0;
        arr_ns        = 0;
        ew_str_light  = red;
        ew_left_light = red;
        ns_light      = red;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    colors col [3];
    int    cur, phase, cnt, guard;
    int    dq [4] = '{2, 1, 0, 0};
    int    ds [4] = '{1, 1, 0, 0};

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        reset = 1'b1;

        // Arrivals at a red light
        repeat (3) step(3'b001, red, red, red);
        chk("lit_q_ews_3", int'(q_ews), 3);
        chk("lit_sensor_ews_1", int'(ew_str_sensor), 1);
        repeat (2) step(3'b000, red, red, red);
        chk("lit_max_wait_3", int'(max_wait), 3);

        // Drain on green, then a legal yellow/all-red
        for (int k = 0; k < 4; k++) begin
            step(3'b000, green, red, red);
            chk("lit_drain_q", int'(q_ews), dq[k]);
            chk("lit_drain_sensor", int'(ew_str_sensor), ds[k]);
        end
        step(3'b000, yellow, red, red);
        step(3'b000, yellow, red, red);
        step(3'b000, red, red, red);
        step(3'b000, red, red, red);

        // Full NS queue: drops at red, none at green
        repeat (15) step(3'b100, red, red, red);
        repeat (2) step(3'b100, red, red, red);
        chk("lit_full_q_ns", int'(q_ns), 15);
        chk("lit_full_drop", int'(drop_cnt), 2);
        repeat (3) step(3'b100, red, red, green);
        chk("lit_green_q_ns", int'(q_ns), 15);
        chk("lit_green_drop", int'(drop_cnt), 2);
        chk("lit_legal_yellow", int'(err_yellow), 0);
        chk("lit_legal_allred", int'(err_allred), 0);

        // Conflict is sticky
        step(3'b000, green, red, yellow);
        chk("lit_conflict_1", int'(err_conflict), 1);
        step(3'b000, green, red, yellow);
        step(3'b000, green, red, red);
        chk("lit_conflict_sticky", int'(err_conflict), 1);

        // Asynchronous reset between edges
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("lit_async_q_ns", int'(q_ns), 0);
        chk("lit_async_conflict", int'(err_conflict), 0);
        check_all();
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // One-cycle yellow followed by an immediate green elsewhere
        step(3'b000, green, red, red);
        step(3'b000, green, red, red);
        step(3'b000, yellow, red, red);
        step(3'b000, red, red, green);
        chk("lit_short_yellow", int'(err_yellow), 1);
        chk("lit_allred", int'(err_allred), 1);

        // Legal G,Y,Y,R,R then NS green
        do_reset();
        step(3'b000, green, red, red);
        step(3'b000, yellow, red, red);
        step(3'b000, yellow, red, red);
        step(3'b000, red, red, red);
        step(3'b000, red, red, red);
        step(3'b000, red, red, green);
        step(3'b000, red, red, green);
        chk("lit_seq_yellow", int'(err_yellow), 0);
        chk("lit_seq_allred", int'(err_allred), 0);
        chk("lit_seq_conflict", int'(err_conflict), 0);

        // Saturation of drop_cnt and wait counters
        do_reset();
        repeat (270) step(3'b111, red, red, red);
        chk("lit_drop_sat", int'(drop_cnt), 255);
        chk("lit_wait_sat", int'(max_wait), 255);

        // Controller-like random traffic
        do_reset();
        cur   = 0;
        phase = 0;
        cnt   = 0;
        for (int n = 0; n < 2300; n++) begin
            logic [2:0] a;
            for (int i = 0; i < 3; i++) col[i] = red;
            col[cur] = (phase == 0) ? green : (phase == 1) ? yellow : red;
            a = '0;
            if (n < 2000)
                for (int i = 0; i < 3; i++) a[i] = ($urandom_range(0, 5) == 0);
            step(a, col[0], col[1], col[2]);
            cnt++;
            if (phase == 0 && cnt >= 3 && (mq[cur] == 0 || cnt >= 10)) begin
                phase = 1;
                cnt   = 0;
            end else if (phase == 1 && cnt == 2) begin
                phase = 2;
                cnt   = 0;
            end else if (phase == 2 && cnt == 2) begin
                phase = 0;
                cnt   = 0;
                cur   = (cur + 1) % 3;
            end
        end
        chk("loop_q_ews_empty", int'(q_ews), 0);
        chk("loop_q_ewl_empty", int'(q_ewl), 0);
        chk("loop_q_ns_empty", int'(q_ns), 0);
        chk("loop_conflict", int'(err_conflict), 0);
        chk("loop_yellow", int'(err_yellow), 0);
        chk("loop_allred", int'(err_allred), 0);
        chk("loop_max_wait_lt40", int'(max_wait < 40), 1);

        // Unconstrained lights and arrivals
        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [2:0] a;
            a = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                guard = ($urandom_range(0, 3) == 0) ? 1 : 0;
                col[i] = guard ? colors'(2'($urandom_range(0, 2))) : red;
            end
            step(a, col[0], col[1], col[2]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
